// File: rtl/parking_pkg.sv
// -----------------------------------------------------------------------------
// parking_pkg
// Shared definitions for the parking-slot timer: default geometry, error codes,
// output-register FSM states and the fee calculation.
// -----------------------------------------------------------------------------
package parking_pkg;

    localparam int N_SLOTS_DEF    = 4;
    localparam int SLOT_W_DEF     = 2;
    localparam int TIME_W_DEF     = 16;
    localparam int FEE_W_DEF      = 16;
    localparam int RATE_DEF       = 5;
    localparam int FREE_UNITS_DEF = 2;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_ENTER_OCC = 2'd1;
    localparam logic [1:0] ERR_EXIT_FREE = 2'd2;
    localparam logic [1:0] ERR_REJECT    = 2'd3;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // Grace units are billed at zero; beyond them each unit costs rate.
    // Arguments are 64 bits wide so the product of a TIME_W-bit count and a
    // FEE_W-bit rate never wraps before it is clamped to fee_max.
    function automatic logic [63:0] fee_calc(
        input logic [63:0] units,
        input logic [63:0] free_units,
        input logic [63:0] rate,
        input logic [63:0] fee_max
    );
        logic [63:0] prod;
        prod = '0;
        if (units > free_units) begin
            prod = (units - free_units) * rate;
        end
        if (prod > fee_max) begin
            prod = fee_max;
        end
        return prod;
    endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// -----------------------------------------------------------------------------
// tick_edge_detect
// Turns the slow divider square wave into a one-cycle pulse per rising edge.
// The input is same-domain and registered at its source, so no synchronizer.
// Pulse is registered: a level rising before edge N yields o_pulse high in the
// cycle after edge N, so consumers update on edge N+1.
//   i_clk    system clock
//   i_rst_n  synchronous active-low reset
//   i_level  divider output level
//   o_pulse  one-cycle pulse per rising edge of i_level
// -----------------------------------------------------------------------------
module tick_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_pulse
);

    logic r_level_q;
    logic r_pulse;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_level_q <= 1'b0;
            r_pulse   <= 1'b0;
        end else begin
            r_level_q <= i_level;
            r_pulse   <= i_level & ~r_level_q;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/parking_slot_timer.sv
// -----------------------------------------------------------------------------
// parking_slot_timer
// Per-bay elapsed-unit counters driven by divider ticks, plus a one-deep
// valid/ready output register carrying a fee record on each accepted exit.
//   CLK_IN      system clock            RST_N       sync active-low reset
//   TICK_IN     divider square wave     ENTER/EXIT  one-cycle car events
//   SLOT        bay addressed           OCC         occupancy per bay
//   FEE_VALID/FEE_READY                 output record handshake
//   FEE_SLOT/FEE_TIME/FEE_AMOUNT        record contents
//   ERR         one-cycle error code (see parking_pkg ERR_*)
// -----------------------------------------------------------------------------
module parking_slot_timer
    import parking_pkg::*;
#(
    parameter int N_SLOTS    = N_SLOTS_DEF,
    parameter int SLOT_W     = SLOT_W_DEF,
    parameter int TIME_W     = TIME_W_DEF,
    parameter int FEE_W      = FEE_W_DEF,
    parameter int RATE       = RATE_DEF,
    parameter int FREE_UNITS = FREE_UNITS_DEF
) (
    input  logic              CLK_IN,
    input  logic              RST_N,
    input  logic              TICK_IN,
    input  logic              ENTER,
    input  logic              EXIT,
    input  logic [SLOT_W-1:0] SLOT,
    output logic [N_SLOTS-1:0] OCC,
    output logic              FEE_VALID,
    input  logic              FEE_READY,
    output logic [SLOT_W-1:0] FEE_SLOT,
    output logic [TIME_W-1:0] FEE_TIME,
    output logic [FEE_W-1:0]  FEE_AMOUNT,
    output logic [1:0]        ERR
);

    localparam logic [TIME_W-1:0] TIME_MAX = '1;
    localparam logic [63:0]       FEE_MAX  = (64'd1 << FEE_W) - 64'd1;

    logic                w_tick;
    logic                w_slot_occ;
    logic                w_out_free;
    logic                w_enter_acc;
    logic                w_exit_acc;
    logic [1:0]          w_err_next;
    logic [63:0]         w_fee_full;
    out_state_e          r_state;
    out_state_e          w_state_next;

    logic [N_SLOTS-1:0]  r_occ;
    logic [TIME_W-1:0]   r_cnt [N_SLOTS];
    logic [SLOT_W-1:0]   r_fee_slot;
    logic [TIME_W-1:0]   r_fee_time;
    logic [FEE_W-1:0]    r_fee_amount;
    logic [1:0]          r_err;

    tick_edge_detect u_tick (
        .i_clk   (CLK_IN),
        .i_rst_n (RST_N),
        .i_level (TICK_IN),
        .o_pulse (w_tick)
    );

    assign w_slot_occ = r_occ[SLOT];
    // Holding register can take a new record if empty or being drained now.
    assign w_out_free = (r_state == OUT_EMPTY) || FEE_READY;

    assign w_enter_acc = ENTER && !EXIT && !w_slot_occ;
    assign w_exit_acc  = EXIT && !ENTER && w_slot_occ && w_out_free;

    // Counter value is the registered one, so a same-cycle tick is excluded.
    assign w_fee_full = fee_calc(64'(r_cnt[SLOT]), 64'(FREE_UNITS),
                                 64'(RATE), FEE_MAX);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_err_next = ERR_NONE;
        if (ENTER && EXIT) begin
            w_err_next = ERR_REJECT;
        end else if (ENTER && w_slot_occ) begin
            w_err_next = ERR_ENTER_OCC;
        end else if (EXIT && !w_slot_occ) begin
            w_err_next = ERR_EXIT_FREE;
        end else if (EXIT && !w_out_free) begin
            w_err_next = ERR_REJECT;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_exit_acc) begin
            w_state_next = OUT_FULL;
        end else if (r_state == OUT_FULL && FEE_READY) begin
            w_state_next = OUT_EMPTY;
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (!RST_N) begin
            r_state <= OUT_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (!RST_N) begin
            r_occ        <= '0;
            // NOTE: the counter array is reset element by element; it is a
            // handful of flops, not a RAM, and must read zero after reset.
            for (int i = 0; i < N_SLOTS; i++) begin
                r_cnt[i] <= '0;
            end
            r_fee_slot   <= '0;
            r_fee_time   <= '0;
            r_fee_amount <= '0;
            r_err        <= ERR_NONE;
        end else begin
            r_err <= w_err_next;
            for (int i = 0; i < N_SLOTS; i++) begin
                // Entry restarts the count and wins over a coincident tick.
                if (w_enter_acc && SLOT == SLOT_W'(i)) begin
                    r_cnt[i] <= '0;
                end else if (w_tick && r_occ[i] && r_cnt[i] != TIME_MAX) begin
                    r_cnt[i] <= r_cnt[i] + TIME_W'(1);
                end
            end
            if (w_enter_acc) begin
                r_occ[SLOT] <= 1'b1;
            end
            if (w_exit_acc) begin
                r_occ[SLOT]  <= 1'b0;
                r_fee_slot   <= SLOT;
                r_fee_time   <= r_cnt[SLOT];
                r_fee_amount <= FEE_W'(w_fee_full);
            end
        end
    end

    assign OCC        = r_occ;
    assign FEE_VALID  = (r_state == OUT_FULL);
    assign FEE_SLOT   = r_fee_slot;
    assign FEE_TIME   = r_fee_time;
    assign FEE_AMOUNT = r_fee_amount;
    assign ERR        = r_err;

endmodule

// File: tb/tb_parking_slot_timer.sv
// -----------------------------------------------------------------------------
// tb_parking_slot_timer
// Directed bench. Three instances share stimulus: default parameters, a
// 4-bit counter variant, and a high-rate variant for fee saturation.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_parking_slot_timer;

    logic        clk;
    logic        rst_n;
    logic        tick_in;
    logic        enter;
    logic        exit_ev;
    logic [1:0]  slot;
    logic        fee_ready;

    logic [3:0]  occ;
    logic        fee_valid;
    logic [1:0]  fee_slot;
    logic [15:0] fee_time;
    logic [15:0] fee_amount;
    logic [1:0]  err;

    logic [3:0]  s_occ;
    logic        s_valid;
    logic [1:0]  s_slot;
    logic [3:0]  s_time;
    logic [15:0] s_amount;
    logic [1:0]  s_err;

    logic [3:0]  h_occ;
    logic        h_valid;
    logic [1:0]  h_slot;
    logic [15:0] h_time;
    logic [15:0] h_amount;
    logic [1:0]  h_err;

    int n_tests;
    int n_fail;

    parking_slot_timer dut (
        .CLK_IN(clk), .RST_N(rst_n), .TICK_IN(tick_in), .ENTER(enter),
        .EXIT(exit_ev), .SLOT(slot), .OCC(occ), .FEE_VALID(fee_valid),
        .FEE_READY(fee_ready), .FEE_SLOT(fee_slot), .FEE_TIME(fee_time),
        .FEE_AMOUNT(fee_amount), .ERR(err)
    );

    parking_slot_timer #(.TIME_W(4)) dut_small (
        .CLK_IN(clk), .RST_N(rst_n), .TICK_IN(tick_in), .ENTER(enter),
        .EXIT(exit_ev), .SLOT(slot), .OCC(s_occ), .FEE_VALID(s_valid),
        .FEE_READY(fee_ready), .FEE_SLOT(s_slot), .FEE_TIME(s_time),
        .FEE_AMOUNT(s_amount), .ERR(s_err)
    );

    parking_slot_timer #(.RATE(6000)) dut_rate (
        .CLK_IN(clk), .RST_N(rst_n), .TICK_IN(tick_in), .ENTER(enter),
        .EXIT(exit_ev), .SLOT(slot), .OCC(h_occ), .FEE_VALID(h_valid),
        .FEE_READY(fee_ready), .FEE_SLOT(h_slot), .FEE_TIME(h_time),
        .FEE_AMOUNT(h_amount), .ERR(h_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick_in = 1'b1;
            cyc();
            tick_in = 1'b0;
            cyc();
        end
    endtask

    task automatic do_enter(input logic [1:0] s);
        slot  = s;
        enter = 1'b1;
        cyc();
        enter = 1'b0;
    endtask

    task automatic do_exit(input logic [1:0] s);
        slot    = s;
        exit_ev = 1'b1;
        cyc();
        exit_ev = 1'b0;
    endtask

    task automatic check_record(input string tag, input logic [1:0] s,
                                input logic [15:0] t, input logic [15:0] a);
        check({tag, "_valid"},  32'(fee_valid),  32'd1);
        check({tag, "_slot"},   32'(fee_slot),   32'(s));
        check({tag, "_time"},   32'(fee_time),   32'(t));
        check({tag, "_amount"}, 32'(fee_amount), 32'(a));
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        tick_in   = 1'b0;
        enter     = 1'b0;
        exit_ev   = 1'b0;
        slot      = 2'd0;
        fee_ready = 1'b0;

        // Reset state
        cyc();
        cyc();
        check("rst_occ",    32'(occ),        32'd0);
        check("rst_valid",  32'(fee_valid),  32'd0);
        check("rst_time",   32'(fee_time),   32'd0);
        check("rst_amount", 32'(fee_amount), 32'd0);
        check("rst_err",    32'(err),        32'd0);
        rst_n     = 1'b1;
        fee_ready = 1'b1;
        cyc();

        // Slot 1, 7 units -> (7-2)*5 = 25
        do_enter(2'd1);
        check("t1_occ_in", 32'(occ), 32'b0010);
        check("t1_err",    32'(err), 32'd0);
        tick_n(7);
        do_exit(2'd1);
        check_record("t1", 2'd1, 16'd7, 16'd25);
        check("t1_occ_out", 32'(occ), 32'd0);
        cyc();
        check("t1_drained", 32'(fee_valid), 32'd0);

        // Within grace period -> zero fee
        do_enter(2'd0);
        tick_n(2);
        do_exit(2'd0);
        check_record("t2", 2'd0, 16'd2, 16'd0);
        cyc();
        do_enter(2'd0);
        check("t2_enter_ok", 32'(err), 32'd0);
        do_enter(2'd0);
        check("t2_enter_occ", 32'(err), 32'd1);
        cyc();
        check("t2_err_clear", 32'(err), 32'd0);
        do_exit(2'd3);
        check("t2_exit_free", 32'(err), 32'd2);

        // Backpressure: slot 0 and 2 both at 3 units
        do_enter(2'd2);
        tick_n(3);
        fee_ready = 1'b0;
        do_exit(2'd0);
        check_record("t3a", 2'd0, 16'd3, 16'd5);
        do_exit(2'd2);
        check("t3_reject_err", 32'(err), 32'd3);
        check("t3_reject_occ", 32'(occ), 32'b0100);
        check_record("t3hold", 2'd0, 16'd3, 16'd5);
        tick_n(1);
        check_record("t3stable", 2'd0, 16'd3, 16'd5);
        fee_ready = 1'b1;
        do_exit(2'd2);
        check_record("t3b", 2'd2, 16'd4, 16'd10);
        check("t3_occ", 32'(occ), 32'd0);
        check("t3_err", 32'(err), 32'd0);
        cyc();
        check("t3_drained", 32'(fee_valid), 32'd0);

        // ENTER and EXIT together
        do_enter(2'd1);
        slot    = 2'd1;
        enter   = 1'b1;
        exit_ev = 1'b1;
        cyc();
        enter   = 1'b0;
        exit_ev = 1'b0;
        check("t4_both_err", 32'(err), 32'd3);
        check("t4_both_occ", 32'(occ), 32'b0010);
        do_exit(2'd1);
        check_record("t4", 2'd1, 16'd0, 16'd0);

        // Tick pulse coincident with ENTER is not counted
        tick_in = 1'b1;
        cyc();
        slot  = 2'd3;
        enter = 1'b1;
        cyc();
        enter   = 1'b0;
        tick_in = 1'b0;
        cyc();
        cyc();
        do_exit(2'd3);
        check_record("t4tick", 2'd3, 16'd0, 16'd0);

        // Level held high for 100 cycles counts once
        do_enter(2'd3);
        tick_in = 1'b1;
        for (int i = 0; i < 100; i++) cyc();
        tick_in = 1'b0;
        cyc();
        cyc();
        do_exit(2'd3);
        check_record("t4held", 2'd3, 16'd1, 16'd0);

        // Saturation: 20 units on all three variants
        do_enter(2'd1);
        tick_n(20);
        do_exit(2'd1);
        check_record("t5", 2'd1, 16'd20, 16'd90);
        check("t5_small_time",   32'(s_time),   32'd15);
        check("t5_small_amount", 32'(s_amount), 32'd65);
        check("t5_rate_time",    32'(h_time),   32'd20);
        check("t5_rate_amount",  32'(h_amount), 32'd65535);
        cyc();

        // Reset mid-operation with a held record and occupied bays
        do_enter(2'd0);
        do_enter(2'd1);
        do_enter(2'd2);
        do_enter(2'd3);
        tick_n(3);
        fee_ready = 1'b0;
        do_exit(2'd3);
        check_record("t6pre", 2'd3, 16'd3, 16'd5);
        check("t6pre_occ", 32'(occ), 32'b0111);
        rst_n = 1'b0;
        slot  = 2'd0;
        enter = 1'b1;
        cyc();
        enter = 1'b0;
        check("t6_occ",    32'(occ),        32'd0);
        check("t6_valid",  32'(fee_valid),  32'd0);
        check("t6_slot",   32'(fee_slot),   32'd0);
        check("t6_time",   32'(fee_time),   32'd0);
        check("t6_amount", 32'(fee_amount), 32'd0);
        check("t6_err",    32'(err),        32'd0);
        rst_n = 1'b1;
        cyc();
        do_enter(2'd0);
        check("t6_reenter_err", 32'(err), 32'd0);
        check("t6_reenter_occ", 32'(occ), 32'b0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
